// File: rtl/mem_ctrl_if.sv
// Core-side and RAM-side signal bundle for the byte-serial memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        if_rw_flag;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_len;
  logic [DATA_W-1:0] if_read_data;
  logic              if_done;
  logic [1:0]        ls_rw_flag;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_len;
  logic [DATA_W-1:0] ls_write_data;
  logic [DATA_W-1:0] ls_read_data;
  logic              ls_done;
  logic              mem_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport master (
    output if_rw_flag, if_addr, if_len,
    output ls_rw_flag, ls_addr, ls_len,
    output ls_write_data, ram_din,
    input  if_read_data, if_done,
    input  ls_read_data, ls_done,
    input  mem_busy, ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_rw_flag, if_addr, if_len,
    input  ls_rw_flag, ls_addr, ls_len,
    input  ls_write_data, ram_din,
    output if_read_data, if_done,
    output ls_read_data, ls_done,
    output mem_busy, ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller for fetch and load/store ports.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration (default: LS priority).
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        cur_len;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] rd_buf;
  logic              cur_ls;

  logic              if_pend;
  logic              if_pend_wr;
  logic [ADDR_W-1:0] if_pend_addr;
  logic [1:0]        if_pend_len;
  logic              ls_pend;
  logic              ls_pend_wr;
  logic [ADDR_W-1:0] ls_pend_addr;
  logic [1:0]        ls_pend_len;
  logic [DATA_W-1:0] ls_pend_wdata;

  logic              if_live;
  logic              ls_live;
  logic              if_req;
  logic              ls_req;
  logic              fin;
  logic              can_grant;
  logic              pick_ls;
  logic              ls_first;
  logic              g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [1:0]        g_len;
  logic [DATA_W-1:0] g_wdata;
  logic [1:0]        cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] buf_nx;

  // 01 and 10 are requests; 00 and 11 are ignored
  assign if_live   = ^bus.if_rw_flag;
  assign ls_live   = ^bus.ls_rw_flag;
  assign if_req    = if_pend | if_live;
  assign ls_req    = ls_pend | ls_live;
  assign fin       = (state != IDLE) && (cnt == cur_len);
  assign can_grant = (state == IDLE) || fin;
  assign pick_ls   = ls_req && (!if_req || ls_first);
  assign cnt_nx    = cnt + 2'd1;
  assign addr_nx   = cur_addr + ADDR_W'(cnt) + ADDR_W'(1);
  assign buf_nx    = rd_buf
                   | (DATA_W'(bus.ram_din) << {cnt, 3'b000});
  assign bus.mem_busy = (state != IDLE) | if_pend | ls_pend;

`ifdef MEM_CTRL_RR_ARB_EN
  logic last_ls;

  assign ls_first = !last_ls;

  // only a real contention moves the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls <= 1'b0;
    end else if (can_grant && if_req && ls_req) begin
      last_ls <= pick_ls;
    end
  end
`else
  assign ls_first = 1'b1;
`endif

  always_comb begin
    g_wr    = if_pend ? if_pend_wr : bus.if_rw_flag[1];
    g_addr  = if_pend ? if_pend_addr : bus.if_addr;
    g_len   = if_pend ? if_pend_len : bus.if_len;
    g_wdata = '0;
    if (pick_ls) begin
      g_wr    = ls_pend ? ls_pend_wr : bus.ls_rw_flag[1];
      g_addr  = ls_pend ? ls_pend_addr : bus.ls_addr;
      g_len   = ls_pend ? ls_pend_len : bus.ls_len;
      g_wdata = ls_pend ? ls_pend_wdata : bus.ls_write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      cur_len          <= '0;
      cur_addr         <= '0;
      cur_wdata        <= '0;
      rd_buf           <= '0;
      cur_ls           <= 1'b0;
      if_pend          <= 1'b0;
      if_pend_wr       <= 1'b0;
      if_pend_addr     <= '0;
      if_pend_len      <= '0;
      ls_pend          <= 1'b0;
      ls_pend_wr       <= 1'b0;
      ls_pend_addr     <= '0;
      ls_pend_len      <= '0;
      ls_pend_wdata    <= '0;
      bus.if_read_data <= '0;
      bus.if_done      <= 1'b0;
      bus.ls_read_data <= '0;
      bus.ls_done      <= 1'b0;
      bus.ram_addr     <= '0;
      bus.ram_wr       <= 1'b0;
      bus.ram_dout     <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;

      unique case (state)
        READ: begin
          rd_buf       <= buf_nx;
          bus.ram_addr <= addr_nx;
          if (fin) begin
            state <= IDLE;
            if (cur_ls) begin
              bus.ls_done      <= 1'b1;
              bus.ls_read_data <= buf_nx;
            end else begin
              bus.if_done      <= 1'b1;
              bus.if_read_data <= buf_nx;
            end
          end else begin
            cnt <= cnt_nx;
          end
        end
        WRITE: begin
          if (fin) begin
            state       <= IDLE;
            bus.ram_wr  <= 1'b0;
            bus.ls_done <= cur_ls;
            bus.if_done <= !cur_ls;
          end else begin
            cnt          <= cnt_nx;
            bus.ram_addr <= addr_nx;
            bus.ram_dout <= cur_wdata[{cnt_nx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase

      // a finishing edge doubles as the next grant edge
      if (can_grant && (if_req || ls_req)) begin
        state        <= g_wr ? WRITE : READ;
        cnt          <= '0;
        cur_len      <= g_len;
        cur_addr     <= g_addr;
        cur_wdata    <= g_wdata;
        cur_ls       <= pick_ls;
        rd_buf       <= '0;
        bus.ram_addr <= g_addr;
        bus.ram_wr   <= g_wr;
        if (g_wr) begin
          bus.ram_dout <= g_wdata[7:0];
        end
      end

      if (can_grant && pick_ls) begin
        ls_pend <= 1'b0;
        if (if_live && !if_pend) begin
          if_pend      <= 1'b1;
          if_pend_wr   <= bus.if_rw_flag[1];
          if_pend_addr <= bus.if_addr;
          if_pend_len  <= bus.if_len;
        end
      end else if (can_grant && if_req) begin
        if_pend <= 1'b0;
        if (ls_live && !ls_pend) begin
          ls_pend       <= 1'b1;
          ls_pend_wr    <= bus.ls_rw_flag[1];
          ls_pend_addr  <= bus.ls_addr;
          ls_pend_len   <= bus.ls_len;
          ls_pend_wdata <= bus.ls_write_data;
        end
      end else if (!can_grant) begin
        if (if_live) begin
          if_pend      <= 1'b1;
          if_pend_wr   <= bus.if_rw_flag[1];
          if_pend_addr <= bus.if_addr;
          if_pend_len  <= bus.if_len;
        end
        if (ls_live) begin
          ls_pend       <= 1'b1;
          ls_pend_wr    <= bus.ls_rw_flag[1];
          ls_pend_addr  <= bus.ls_addr;
          ls_pend_len   <= bus.ls_len;
          ls_pend_wdata <= bus.ls_write_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected done/write events are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          ls;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t dq[$];
  wr_t   wq[$];

  logic [7:0]  mem [0:4095];
  logic [31:0] fw  [0:7];
  int cyc = 0;
  int total = 0;
  int passed = 0;

  assign bus.ram_din = mem[bus.ram_addr[11:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, act, exp);
  endtask

  task automatic exp_done(input bit ls,
                          input logic [31:0] d,
                          input int c);
    done_t e;
    e.ls = ls;
    e.data = d;
    e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a,
                        input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic mon_done(input bit ls, input logic [31:0] d);
    done_t e;
    total++;
    if (dq.size() == 0) begin
      $display("FAIL done_unexpected: port %0d data 0x%08h cyc %0d",
               ls, d, cyc);
    end else begin
      e = dq.pop_front();
      if (e.ls == ls && e.data === d && e.cyc == cyc) passed++;
      else $display(
        "FAIL done: got port %0d 0x%08h cyc %0d want port %0d 0x%08h cyc %0d",
        ls, d, cyc, e.ls, e.data, e.cyc);
    end
  endtask

  task automatic mon_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    total++;
    if (wq.size() == 0) begin
      $display("FAIL wr_unexpected: 0x%02h @0x%08h", d, a);
    end else begin
      e = wq.pop_front();
      if (e.a === a && e.d === d) passed++;
      else $display("FAIL wr: got 0x%02h @0x%08h want 0x%02h @0x%08h",
                    d, a, e.d, e.a);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_done) mon_done(1'b0, bus.if_read_data);
      if (bus.ls_done) mon_done(1'b1, bus.ls_read_data);
      if (bus.ram_wr) mon_wr(bus.ram_addr, bus.ram_dout);
    end
  end

  task automatic drive(input logic [1:0]  if_rw,
                       input logic [31:0] if_a,
                       input logic [1:0]  if_l,
                       input logic [1:0]  ls_rw,
                       input logic [31:0] ls_a,
                       input logic [1:0]  ls_l,
                       input logic [31:0] ls_d);
    bus.if_rw_flag    = if_rw;
    bus.if_addr       = if_a;
    bus.if_len        = if_l;
    bus.ls_rw_flag    = ls_rw;
    bus.ls_addr       = ls_a;
    bus.ls_len        = ls_l;
    bus.ls_write_data = ls_d;
    @(negedge clk);
    bus.if_rw_flag = 2'b00;
    bus.ls_rw_flag = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while ((dq.size() != 0 || wq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dq.size() == 0 && wq.size() == 0) passed++;
    else $display("FAIL drain_timeout: %0d done, %0d writes outstanding",
                  dq.size(), wq.size());
    @(negedge clk);
  endtask

  task automatic wait_if_done();
    int n = 0;
    while (!bus.if_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.if_done) passed++;
    else $display("FAIL if_done_timeout: waited %0d cycles", n);
  endtask

  initial begin
    int c;
    logic busy_ok;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[12'h100] = 8'h13;
    mem[12'h101] = 8'h05;
    mem[12'h102] = 8'h10;
    mem[12'h103] = 8'h00;
    mem[12'h200] = 8'h34;
    mem[12'h201] = 8'h12;
    mem[12'hFFE] = 8'hAA;
    mem[12'hFFF] = 8'hBB;
    fw = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
           32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    bus.if_rw_flag    = 2'b00;
    bus.if_addr       = '0;
    bus.if_len        = '0;
    bus.ls_rw_flag    = 2'b00;
    bus.ls_addr       = '0;
    bus.ls_len        = '0;
    bus.ls_write_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", bus.mem_busy, 32'h0);
    chk("reset_ram_addr", bus.ram_addr, 32'h0);
    chk("reset_ram_wr", bus.ram_wr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 4-byte fetch
    c = cyc;
    exp_done(1'b0, 32'h00100513, c + 5);
    drive(2'b01, 32'h100, 2'b11, 2'b00, 32'h0, 2'b00, 32'h0);
    chk("fetch_addr0", bus.ram_addr, 32'h100);
    chk("fetch_busy", bus.mem_busy, 32'h1);
    repeat (3) @(negedge clk);
    chk("fetch_addr3", bus.ram_addr, 32'h103);
    drain();

    // simultaneous IF + LS reads: LS first, IF from pending
    c = cyc;
    exp_done(1'b1, 32'h00001234, c + 3);
    exp_done(1'b0, 32'h00100513, c + 7);
    drive(2'b01, 32'h100, 2'b11, 2'b01, 32'h200, 2'b01, 32'h0);
    busy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!bus.mem_busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    chk("pair_busy_held", busy_ok, 32'h1);
    chk("pair_busy_done", bus.mem_busy, 32'h0);
    drain();

    // single-byte store; ls_read_data keeps the previous load
    c = cyc;
    exp_wr(32'h30004, 8'hAB);
    exp_done(1'b1, 32'h00001234, c + 2);
    drive(2'b00, 32'h0, 2'b00, 2'b10, 32'h30004, 2'b00, 32'h000000AB);
    drain();

    // rw_flag 11 is not a request
    drive(2'b11, 32'h100, 2'b11, 2'b00, 32'h0, 2'b00, 32'h0);
    chk("rw11_ignored", bus.mem_busy, 32'h0);
    drain();

    // back-to-back fetches issued in the done cycle
    c = cyc;
    exp_done(1'b0, fw[0], c + 5);
    drive(2'b01, 32'h0, 2'b11, 2'b00, 32'h0, 2'b00, 32'h0);
    for (int k = 1; k < 8; k++) begin
      wait_if_done();
      c = cyc;
      exp_done(1'b0, fw[k], c + 5);
      drive(2'b01, 32'(4 * k), 2'b11, 2'b00, 32'h0, 2'b00, 32'h0);
    end
    drain();

    // reset in the middle of a 4-byte store
    exp_wr(32'h40, 8'h11);
    exp_wr(32'h41, 8'h22);
    drive(2'b00, 32'h0, 2'b00, 2'b10, 32'h40, 2'b11, 32'h44332211);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ram_wr", bus.ram_wr, 32'h0);
    chk("midrst_ram_addr", bus.ram_addr, 32'h0);
    chk("midrst_ram_dout", bus.ram_dout, 32'h0);
    chk("midrst_busy", bus.mem_busy, 32'h0);
    chk("midrst_if_data", bus.if_read_data, 32'h0);
    chk("midrst_ls_data", bus.ls_read_data, 32'h0);
    chk("midrst_dones", {bus.if_done, bus.ls_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();

    // first contention after reset: LS wins in both modes
    c = cyc;
    exp_done(1'b1, 32'h00000006, c + 2);
    exp_done(1'b0, 32'h00000005, c + 3);
    drive(2'b01, 32'h5, 2'b00, 2'b01, 32'h6, 2'b00, 32'h0);
    drain();

    c = cyc;
`ifdef MEM_CTRL_RR_ARB_EN
    exp_done(1'b0, 32'h00000007, c + 2);
    exp_done(1'b1, 32'h00000008, c + 3);
`else
    exp_done(1'b1, 32'h00000008, c + 2);
    exp_done(1'b0, 32'h00000007, c + 3);
`endif
    drive(2'b01, 32'h7, 2'b00, 2'b01, 32'h8, 2'b00, 32'h0);
    drain();

    // address wraps from the top of the space
    c = cyc;
    exp_done(1'b1, 32'h0100BBAA, c + 5);
    drive(2'b00, 32'h0, 2'b00, 2'b01, 32'hFFFFFFFE, 2'b11, 32'h0);
    repeat (2) @(negedge clk);
    chk("wrap_addr", bus.ram_addr, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
